// File: rtl/regfile_wb_sched_if.sv
// Write-back request bus between the execution units and the register file
// write-back scheduler: one valid/sel/data lane per requester, one-hot ready.
interface regfile_wb_sched_if #(
    parameter int WIDTH     = 32,
    parameter int RSELWIDTH = 4,
    parameter int NREQ      = 3
);
    logic [NREQ-1:0]           req_valid;
    logic [NREQ*RSELWIDTH-1:0] req_sel;
    logic [NREQ*WIDTH-1:0]     req_data;
    logic [NREQ-1:0]           req_ready;

    modport master (output req_valid, req_sel, req_data, input req_ready);
    modport slave  (input req_valid, req_sel, req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_sched.sv
// Round-robin write-back scheduler and RAW/WAW scoreboard for a single-write-port regfile.
// Optional REGFILE_WB_SCHED_BYPASS_EN adds forwarding of the in-flight write to decode.
module regfile_wb_sched #(
    parameter int WIDTH     = 32,
    parameter int RSELWIDTH = 4,
    parameter int NREQ      = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_sched_if.slave    wb,
    input  logic                 issue_valid,
    input  logic [RSELWIDTH-1:0] issue_sel,
    output logic                 issue_ready,
    input  logic [RSELWIDTH-1:0] asel,
    input  logic [RSELWIDTH-1:0] bsel,
    input  logic [RSELWIDTH-1:0] csel,
    output logic                 a_busy,
    output logic                 b_busy,
    output logic                 c_busy,
`ifdef REGFILE_WB_SCHED_BYPASS_EN
    output logic                 a_fwd,
    output logic                 b_fwd,
    output logic                 c_fwd,
    output logic [WIDTH-1:0]     fwd_data,
`endif
    output logic                 we,
    output logic [RSELWIDTH-1:0] wsel,
    output logic [WIDTH-1:0]     wdata
);
    localparam int unsigned NR    = NREQ;
    localparam int unsigned PTRW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NREGS = 2 ** RSELWIDTH;

    logic [PTRW-1:0]  rr;
    logic [PTRW-1:0]  gidx;
    logic             grant_any;
    logic [NREQ-1:0]  grant;
    int unsigned      idx;
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic             a_hit, b_hit, c_hit, issue_hit;

    // First valid requester at or after the rr pointer, wrapping modulo NREQ.
    always_comb begin
        grant_any = 1'b0;
        gidx      = '0;
        idx       = 0;
        grant     = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            idx = (32'(rr) + k) % NR;
            if (!grant_any && wb.req_valid[idx]) begin
                grant_any = 1'b1;
                gidx      = PTRW'(idx);
            end
        end
        if (!rst_n)
            grant_any = 1'b0;
        if (grant_any)
            grant[gidx] = 1'b1;
    end

    assign wb.req_ready = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr    <= '0;
            we    <= 1'b0;
            wsel  <= '0;
            wdata <= '0;
        end else begin
            we <= grant_any;
            if (grant_any) begin
                rr    <= (gidx == PTRW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                wsel  <= wb.req_sel[int'(gidx)*RSELWIDTH +: RSELWIDTH];
                wdata <= wb.req_data[int'(gidx)*WIDTH +: WIDTH];
            end
        end
    end

`ifdef REGFILE_WB_SCHED_BYPASS_EN
    assign a_hit     = we && (wsel == asel);
    assign b_hit     = we && (wsel == bsel);
    assign c_hit     = we && (wsel == csel);
    assign issue_hit = we && (wsel == issue_sel);
    assign a_fwd     = a_hit;
    assign b_fwd     = b_hit;
    assign c_fwd     = c_hit;
    assign fwd_data  = wdata;
`else
    assign a_hit     = 1'b0;
    assign b_hit     = 1'b0;
    assign c_hit     = 1'b0;
    assign issue_hit = 1'b0;
`endif

    assign issue_ready = ~busy[issue_sel] | issue_hit;
    assign a_busy      = busy[asel] & ~a_hit;
    assign b_busy      = busy[bsel] & ~b_hit;
    assign c_busy      = busy[csel] & ~c_hit;

    // Clear applied before set so a same-cycle reservation of the written register survives.
    always_comb begin
        busy_next = busy;
        if (we)
            busy_next[wsel] = 1'b0;
        if (issue_valid && issue_ready)
            busy_next[issue_sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy <= '0;
        else
            busy <= busy_next;
    end
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: reset, single write, round robin, WAW stall,
// same-cycle set/clear, bypass/no-bypass hazard behaviour, reset mid-transfer.
module tb_regfile_wb_sched;
    localparam int WIDTH     = 32;
    localparam int RSELWIDTH = 4;
    localparam int NREQ      = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 issue_valid;
    logic [RSELWIDTH-1:0] issue_sel;
    logic                 issue_ready;
    logic [RSELWIDTH-1:0] asel, bsel, csel;
    logic                 a_busy, b_busy, c_busy;
    logic                 we;
    logic [RSELWIDTH-1:0] wsel;
    logic [WIDTH-1:0]     wdata;
`ifdef REGFILE_WB_SCHED_BYPASS_EN
    logic                 a_fwd, b_fwd, c_fwd;
    logic [WIDTH-1:0]     fwd_data;
`endif

    int checks   = 0;
    int failures = 0;
    int rr_exp;
    logic [WIDTH-1:0] rr_data [3];

    regfile_wb_sched_if #(.WIDTH(WIDTH), .RSELWIDTH(RSELWIDTH), .NREQ(NREQ)) wbif ();

    regfile_wb_sched #(.WIDTH(WIDTH), .RSELWIDTH(RSELWIDTH), .NREQ(NREQ)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb          (wbif.slave),
        .issue_valid (issue_valid),
        .issue_sel   (issue_sel),
        .issue_ready (issue_ready),
        .asel        (asel),
        .bsel        (bsel),
        .csel        (csel),
        .a_busy      (a_busy),
        .b_busy      (b_busy),
        .c_busy      (c_busy),
`ifdef REGFILE_WB_SCHED_BYPASS_EN
        .a_fwd       (a_fwd),
        .b_fwd       (b_fwd),
        .c_fwd       (c_fwd),
        .fwd_data    (fwd_data),
`endif
        .we          (we),
        .wsel        (wsel),
        .wdata       (wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [RSELWIDTH-1:0] s, input logic [WIDTH-1:0] d);
        wbif.req_sel[i*RSELWIDTH +: RSELWIDTH] = s;
        wbif.req_data[i*WIDTH +: WIDTH]        = d;
    endtask

    initial begin
        rst_n          = 1'b0;
        issue_valid    = 1'b0;
        issue_sel      = '0;
        asel           = '0;
        bsel           = '0;
        csel           = '0;
        wbif.req_valid = 3'b111;
        wbif.req_sel   = '0;
        wbif.req_data  = '0;

        // Reset state
        #3;
        check("rst_req_ready", 32'(wbif.req_ready), 32'h0);
        check("rst_we", 32'(we), 32'h0);
        check("rst_wsel", 32'(wsel), 32'h0);
        check("rst_wdata", wdata, 32'h0);
        for (int r = 0; r < 16; r++) begin
            asel = RSELWIDTH'(r);
            #1;
            check("rst_busy", 32'(a_busy), 32'h0);
        end
        wbif.req_valid = '0;
        asel = '0;
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_issue_ready", 32'(issue_ready), 32'h1);

        // Single write to r5
        issue_valid = 1'b1;
        issue_sel   = 4'd5;
        bsel        = 4'd5;
        #1;
        check("r5_issue_ready", 32'(issue_ready), 32'h1);
        tick();
        issue_valid = 1'b0;
        #1;
        check("r5_b_busy", 32'(b_busy), 32'h1);
        check("r5_we_idle", 32'(we), 32'h0);
        wbif.req_valid = 3'b001;
        set_req(0, 4'd5, 32'hDEADBEEF);
        #1;
        check("r5_grant", 32'(wbif.req_ready), 32'h1);
        tick();
        wbif.req_valid = '0;
        #1;
        check("r5_we", 32'(we), 32'h1);
        check("r5_wsel", 32'(wsel), 32'h5);
        check("r5_wdata", wdata, 32'hDEADBEEF);
`ifdef REGFILE_WB_SCHED_BYPASS_EN
        check("r5_b_busy_fwd", 32'(b_busy), 32'h0);
        check("r5_b_fwd", 32'(b_fwd), 32'h1);
`else
        check("r5_b_busy_inflight", 32'(b_busy), 32'h1);
`endif
        tick();
        check("r5_we_done", 32'(we), 32'h0);
        check("r5_wdata_hold", wdata, 32'hDEADBEEF);
        check("r5_b_clear", 32'(b_busy), 32'h0);

        // Round robin: pointer is 1 after the grant to requester 0
        rr_data[0] = 32'h1111_0001;
        rr_data[1] = 32'h2222_0002;
        rr_data[2] = 32'h3333_0003;
        for (int i = 0; i < 3; i++)
            set_req(i, RSELWIDTH'(i + 1), rr_data[i]);
        wbif.req_valid = 3'b111;
        rr_exp = 1;
        #1;
        for (int n = 0; n < 6; n++) begin
            check("rr_grant", 32'(wbif.req_ready), 32'(1 << rr_exp));
            tick();
            check("rr_we", 32'(we), 32'h1);
            check("rr_wsel", 32'(wsel), 32'(rr_exp + 1));
            check("rr_wdata", wdata, rr_data[rr_exp]);
            rr_exp = (rr_exp + 1) % 3;
        end
        wbif.req_valid = '0;
        asel = 4'd2;
        tick();
        check("rr_we_idle", 32'(we), 32'h0);
        check("rr_unfiltered_busy", 32'(a_busy), 32'h0);

        // WAW stall on r7; pointer is back at 1
        issue_valid = 1'b1;
        issue_sel   = 4'd7;
        #1;
        check("waw_first_ready", 32'(issue_ready), 32'h1);
        tick();
        check("waw_stall0", 32'(issue_ready), 32'h0);
        tick();
        check("waw_stall1", 32'(issue_ready), 32'h0);
        issue_valid    = 1'b0;
        wbif.req_valid = 3'b100;
        set_req(2, 4'd7, 32'hA5A5_0007);
        #1;
        check("waw_grant", 32'(wbif.req_ready), 32'h4);
        check("waw_stall2", 32'(issue_ready), 32'h0);
        tick();
        wbif.req_valid = '0;
        #1;
        check("waw_we", 32'(we), 32'h1);
        check("waw_wsel", 32'(wsel), 32'h7);
`ifdef REGFILE_WB_SCHED_BYPASS_EN
        check("waw_ready_fwd", 32'(issue_ready), 32'h1);
`else
        check("waw_stall_inflight", 32'(issue_ready), 32'h0);
`endif
        tick();
        check("waw_ready_after", 32'(issue_ready), 32'h1);

        // Same-cycle set/clear on r4 (pointer now 0)
        asel           = 4'd4;
        wbif.req_valid = 3'b001;
        set_req(0, 4'd4, 32'h0000_0044);
        #1;
        check("sc_grant", 32'(wbif.req_ready), 32'h1);
        tick();
        wbif.req_valid = '0;
        issue_valid    = 1'b1;
        issue_sel      = 4'd4;
        #1;
        check("sc_we", 32'(we), 32'h1);
        check("sc_issue_ready", 32'(issue_ready), 32'h1);
        tick();
        issue_valid = 1'b0;
        #1;
        check("sc_set_wins", 32'(a_busy), 32'h1);
        wbif.req_valid = 3'b010;
        set_req(1, 4'd4, 32'h0000_0444);
        tick();
        wbif.req_valid = '0;
        tick();
        check("sc_cleared", 32'(a_busy), 32'h0);

        // In-flight write vs. read select r9 (pointer now 2, requester 1 wins alone)
        issue_valid = 1'b1;
        issue_sel   = 4'd9;
        asel        = 4'd9;
        tick();
        issue_valid = 1'b0;
        #1;
        check("byp_busy_before", 32'(a_busy), 32'h1);
        wbif.req_valid = 3'b010;
        set_req(1, 4'd9, 32'h12345678);
        #1;
        check("byp_grant", 32'(wbif.req_ready), 32'h2);
        tick();
        wbif.req_valid = '0;
        #1;
        check("byp_we", 32'(we), 32'h1);
        check("byp_wdata", wdata, 32'h12345678);
`ifdef REGFILE_WB_SCHED_BYPASS_EN
        check("byp_a_fwd", 32'(a_fwd), 32'h1);
        check("byp_a_busy", 32'(a_busy), 32'h0);
        check("byp_fwd_data", fwd_data, 32'h12345678);
`else
        check("byp_a_busy_nofwd", 32'(a_busy), 32'h1);
`endif
        tick();
        check("byp_a_clear", 32'(a_busy), 32'h0);

        // Reset mid-transfer (pointer now 2)
        issue_valid = 1'b1;
        issue_sel   = 4'd6;
        asel        = 4'd6;
        tick();
        issue_valid    = 1'b0;
        wbif.req_valid = 3'b101;
        set_req(0, 4'd6, 32'h6666_6666);
        set_req(2, 4'd3, 32'h3333_3333);
        tick();
        check("mid_we", 32'(we), 32'h1);
        check("mid_busy", 32'(a_busy), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", 32'(we), 32'h0);
        check("mid_rst_ready", 32'(wbif.req_ready), 32'h0);
        check("mid_rst_busy", 32'(a_busy), 32'h0);
        check("mid_rst_wdata", wdata, 32'h0);
        wbif.req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_after_we", 32'(we), 32'h0);
        check("mid_after_issue_ready", 32'(issue_ready), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
